// File: rtl/mem_responder.sv
// Unified word-organised RAM responder: one request per cycle, fixed pipelined read latency, low ROM region.
// Optional MEM_ERR_EN: misaligned, out-of-range and ROM-write errors are reported on rsp_err in request order.
package isa_types;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    write_byte     = 2'd0,
    write_halfword = 2'd1,
    write_word     = 2'd2
  } write_width_t;
endpackage

module mem_responder
  import isa_types::*;
#(
  parameter int              DEPTH_WORDS  = 1024,
  parameter logic [XLEN-1:0] ROM_BYTES    = 32'h400,
  parameter int              READ_LATENCY = 2,
  parameter                  INIT_FILE    = "program.hex",
  parameter int              NUM_LANES    = XLEN/8
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  write_width_t    req_wwidth,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);
  localparam int              IW        = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] TOP_BYTES = XLEN'(4*DEPTH_WORDS);

  logic [NUM_LANES-1:0][7:0] mem_q [DEPTH_WORDS];

  logic [IW-1:0]             idx;
  logic                      oor, rom, mis, wr_ok, rd_go;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wd;
  logic [XLEN-1:0]           rd_word, rd_shift, rd_dat;

  assign idx   = req_addr[IW+1:2];
  assign oor   = req_addr >= TOP_BYTES;
  assign rom   = req_addr < ROM_BYTES;
  assign wr_ok = req_valid & req_we & ~oor & ~rom & ~mis;
  assign rd_go = req_valid & ~req_we;

  always_comb begin
    mis = 1'b0;
    be  = '0;
    wd  = req_wdata;
    case (req_wwidth)
      write_byte: begin
        be[req_addr[1:0]] = 1'b1;
        wd = {NUM_LANES{req_wdata[7:0]}};
      end
      write_halfword: begin
        mis = req_addr[0];
        be[{req_addr[1], 1'b1}] = 1'b1;
        be[{req_addr[1], 1'b0}] = 1'b1;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        mis = |req_addr[1:0];
        be  = '1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (wr_ok)
      for (int l = 0; l < NUM_LANES; l++)
        if (be[l]) mem_q[idx][l] <= wd[l];
  end

  // Out-of-range never aliases: the index is only trusted when in range.
  assign rd_word  = oor ? '0 : mem_q[idx];
  assign rd_shift = rd_word >> {req_addr[1:0], 3'b000};

  logic [READ_LATENCY:1]           vld_pipe;
  logic [READ_LATENCY:1][XLEN-1:0] dat_pipe;

`ifdef MEM_ERR_EN
  logic                  err_in;
  logic [READ_LATENCY:1] err_pipe;

  assign err_in = req_valid & (oor | mis | (req_we & rom));
  assign rd_dat = err_in ? '0 : rd_shift;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_pipe <= '0;
    end else begin
      err_pipe[1] <= err_in;
      for (int k = 2; k <= READ_LATENCY; k++) err_pipe[k] <= err_pipe[k-1];
    end
  end

  assign rsp_err = err_pipe[READ_LATENCY];
`else
  assign rd_dat  = rd_shift;
  assign rsp_err = 1'b0;
`endif

  // Data stages advance only behind a valid read so rsp_rdata holds between pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_go;
      if (rd_go) dat_pipe[1] <= rd_dat;
      for (int k = 2; k <= READ_LATENCY; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
      end
    end
  end

  assign rsp_valid = vld_pipe[READ_LATENCY];
  assign rsp_rdata = dat_pipe[READ_LATENCY];
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: vector table for pipelined read/write traffic plus reset and error sequences.
module tb_mem_responder;
  import isa_types::*;

  logic         clock, reset_n, req_valid, req_we;
  logic [31:0]  req_addr, req_wdata;
  write_width_t req_wwidth;
  logic         rsp_valid, rsp_err;
  logic [31:0]  rsp_rdata;

  int n_chk = 0;
  int n_fail = 0;

  mem_responder #(
    .DEPTH_WORDS(1024), .ROM_BYTES(32'h400), .READ_LATENCY(2), .INIT_FILE("")
  ) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wwidth(req_wwidth), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive, take one rising edge, check outputs #1 later, return at next negedge.
  task automatic step(input string name, input logic v, input logic we, input logic [31:0] a,
                      input write_width_t w, input logic [31:0] d,
                      input logic ev, input logic [31:0] erd, input logic eerr, input bit cerr);
    req_valid = v; req_we = we; req_addr = a; req_wwidth = w; req_wdata = d;
    @(posedge clock);
    #1;
    chk({name, ".valid"}, 32'(rsp_valid), 32'(ev));
    chk({name, ".rdata"}, rsp_rdata, erd);
    if (cerr) chk({name, ".err"}, 32'(rsp_err), 32'(eerr));
    @(negedge clock);
  endtask

  typedef struct {
    logic v, we; logic [31:0] a; write_width_t w; logic [31:0] d;
    logic ev; logic [31:0] erd;
  } vec_t;

  vec_t tbl[31];

  initial begin
    // Responses to row i's read appear in row i+1's expectations (READ_LATENCY=2).
    tbl[0]  = '{1, 1, 32'h800,      write_word,     32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{1, 0, 32'h800,      write_word,     32'h0,        0, 32'h0};
    tbl[2]  = '{1, 1, 32'h804,      write_word,     32'h11223344, 1, 32'hDEADBEEF};
    tbl[3]  = '{1, 1, 32'h808,      write_word,     32'h55667788, 0, 32'hDEADBEEF};
    tbl[4]  = '{1, 1, 32'h801,      write_byte,     32'h123456AA, 0, 32'hDEADBEEF};
    tbl[5]  = '{1, 0, 32'h800,      write_word,     32'h0,        0, 32'hDEADBEEF};
    tbl[6]  = '{1, 0, 32'h803,      write_byte,     32'h0,        1, 32'hDEADAAEF};
    tbl[7]  = '{1, 0, 32'h802,      write_halfword, 32'h0,        1, 32'h000000DE};
    tbl[8]  = '{1, 0, 32'h800,      write_word,     32'h0,        1, 32'h0000DEAD};
    tbl[9]  = '{1, 0, 32'h804,      write_word,     32'h0,        1, 32'hDEADAAEF};
    tbl[10] = '{1, 0, 32'h808,      write_word,     32'h0,        1, 32'h11223344};
    tbl[11] = '{1, 1, 32'h100,      write_word,     32'h12345678, 1, 32'h55667788};
    tbl[12] = '{1, 0, 32'h100,      write_word,     32'h0,        0, 32'h55667788};
    tbl[13] = '{1, 1, 32'h806,      write_halfword, 32'h0000ABCD, 1, 32'hCAFEF00D};
    tbl[14] = '{1, 1, 32'h805,      write_halfword, 32'h00009999, 0, 32'hCAFEF00D};
    tbl[15] = '{1, 1, 32'h80A,      write_word,     32'h0,        0, 32'hCAFEF00D};
    tbl[16] = '{1, 1, 32'h1000,     write_byte,     32'hFF,       0, 32'hCAFEF00D};
    tbl[17] = '{1, 0, 32'h804,      write_word,     32'h0,        0, 32'hCAFEF00D};
    tbl[18] = '{1, 0, 32'h1000,     write_word,     32'h0,        1, 32'hABCD3344};
    tbl[19] = '{1, 0, 32'hFFFFFFFC, write_word,     32'h0,        1, 32'h0};
    tbl[20] = '{0, 0, 32'h0,        write_word,     32'h0,        1, 32'h0};
    tbl[21] = '{1, 0, 32'h807,      write_byte,     32'h0,        0, 32'h0};
    tbl[22] = '{0, 0, 32'h0,        write_word,     32'h0,        1, 32'h000000AB};
    tbl[23] = '{1, 1, 32'h3FC,      write_word,     32'hFFFFFFFF, 0, 32'h000000AB};
    tbl[24] = '{1, 1, 32'h400,      write_word,     32'h0000005A, 0, 32'h000000AB};
    tbl[25] = '{1, 1, 32'hFFC,      write_word,     32'h87654321, 0, 32'h000000AB};
    tbl[26] = '{1, 0, 32'h3FC,      write_word,     32'h0,        0, 32'h000000AB};
    tbl[27] = '{1, 0, 32'h400,      write_word,     32'h0,        1, 32'h01020304};
    tbl[28] = '{1, 0, 32'hFFC,      write_word,     32'h0,        1, 32'h0000005A};
    tbl[29] = '{0, 0, 32'h0,        write_word,     32'h0,        1, 32'h87654321};
    tbl[30] = '{0, 0, 32'h0,        write_word,     32'h0,        0, 32'h87654321};

    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wwidth = write_word; req_wdata = '0;
    #1;
    dut.mem_q[64]  = 32'hCAFEF00D;
    dut.mem_q[255] = 32'h01020304;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.valid", 32'(rsp_valid), 32'h0);
    chk("reset.rdata", rsp_rdata, 32'h0);
    chk("reset.err", 32'(rsp_err), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
`ifdef MEM_ERR_EN
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].w, tbl[i].d,
           tbl[i].ev, tbl[i].erd, 1'b0, 1'b0);
`else
      step($sformatf("vec%0d", i), tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].w, tbl[i].d,
           tbl[i].ev, tbl[i].erd, 1'b0, 1'b1);
`endif
    end

    // Reset while a read is in flight: outputs clear at once and the read never responds.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h800; req_wwidth = write_word;
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(rsp_valid), 32'h0);
    chk("midrst.rdata", rsp_rdata, 32'h0);
    chk("midrst.err", 32'(rsp_err), 32'h0);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clock);
      #1 chk($sformatf("postrst%0d.valid", c), 32'(rsp_valid), 32'h0);
    end
    @(negedge clock);
    step("intact.req", 1, 0, 32'h800, write_word, 32'h0, 0, 32'h0, 0, 1'b1);
    step("intact.rsp", 0, 0, 32'h0,   write_word, 32'h0, 1, 32'hDEADAAEF, 0, 1'b1);
    step("intact.end", 0, 0, 32'h0,   write_word, 32'h0, 0, 32'hDEADAAEF, 0, 1'b1);

`ifdef MEM_ERR_EN
    step("err.hw805", 1, 1, 32'h805,  write_halfword, 32'h1111, 0, 32'hDEADAAEF, 0, 1'b1);
    step("err.rd806", 1, 0, 32'h806,  write_word,     32'h0,    0, 32'hDEADAAEF, 1, 1'b1);
    step("err.rsp",   0, 0, 32'h0,    write_word,     32'h0,    1, 32'h0,        1, 1'b1);
    step("err.oor",   1, 0, 32'h1000, write_word,     32'h0,    0, 32'h0,        0, 1'b1);
    step("err.oorr",  0, 0, 32'h0,    write_word,     32'h0,    1, 32'h0,        1, 1'b1);
    step("err.rom",   1, 1, 32'h100,  write_word,     32'h12345678, 0, 32'h0,    0, 1'b1);
    step("err.romw",  1, 0, 32'h804,  write_word,     32'h0,    0, 32'h0,        1, 1'b1);
    step("err.chk",   0, 0, 32'h0,    write_word,     32'h0,    1, 32'hABCD3344, 0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
